axis_window_monitor: RTL and testbench

Pass-through AXIS probe that extends the single-counter monitor with saturating beat and stall counters, last-sample capture, and a programmable measurement window that reports beats per window. It sits inline between any AXIS producer and consumer. All statistics are exposed through DREG interfaces (dout/din/dset) for software readout.

---
 rtl/axis_monitor_pkg.sv | 11 +
 rtl/sat_counter.sv | 17 +
 rtl/axis_window_monitor.sv | 92 +++++++++
 tb/tb_axis_window_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_monitor_pkg.sv
// axis_monitor_pkg: window FSM encoding and width-generic saturating increment
package axis_monitor_pkg;
    typedef enum logic {WIN_DISABLED, WIN_RUN} win_state_t;
    localparam int SAT_MAX_W = 64;
    typedef logic [SAT_MAX_W-1:0] sat_t;
    function automatic sat_t sat_inc(input sat_t v, input int w);
        sat_t lim;
        lim = (w >= SAT_MAX_W) ? '1 : (sat_t'(1) << w) - sat_t'(1);
        return (v >= lim) ? v : v + sat_t'(1);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones; clear wins over inc
module sat_counter
    import axis_monitor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clock or posedge reset)
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (inc) count <= WIDTH'(sat_inc(sat_t'(count), WIDTH));
endmodule

// File: rtl/axis_window_monitor.sv
// axis_window_monitor: inline AXIS probe with beat/stall counters, sample capture and windowed rate.
// Define AXIS_MONITOR_PEAK_EN to add the signed peak-sample tracker.
module axis_window_monitor
    import axis_monitor_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int COUNTER_WIDTH = 32,
    parameter int WINDOW_WIDTH  = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DATA_WIDTH-1:0]    m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [COUNTER_WIDTH-1:0] beats_dout,
    input  logic                     beats_dset,
    output logic [COUNTER_WIDTH-1:0] stalls_dout,
    input  logic                     stalls_dset,
    output logic [DATA_WIDTH-1:0]    sample_dout,
    input  logic [DATA_WIDTH-1:0]    sample_din,
    input  logic                     sample_dset,
    output logic [WINDOW_WIDTH-1:0]  window_dout,
    input  logic [WINDOW_WIDTH-1:0]  window_din,
    input  logic                     window_dset,
    output logic [COUNTER_WIDTH-1:0] rate_dout,
    output logic [DATA_WIDTH-1:0]    peak_dout,
    input  logic                     peak_dset
);
    win_state_t state, state_next;
    logic [WINDOW_WIDTH-1:0] timer;
    logic [COUNTER_WIDTH-1:0] acc, rate_next;
    logic beat, win_end, win_clr;

    assign m_tdata  = s_tdata;
    assign m_tvalid = s_tvalid;
    assign s_tready = m_tready;
    assign beat     = s_tvalid && m_tready;

    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_beats (
        .clock(clock), .reset(reset), .clear(beats_dset), .inc(beat), .count(beats_dout)
    );
    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stalls (
        .clock(clock), .reset(reset), .clear(stalls_dset), .inc(s_tvalid && !m_tready), .count(stalls_dout)
    );
    sat_counter #(.WIDTH(COUNTER_WIDTH)) u_acc (
        .clock(clock), .reset(reset), .clear(win_clr), .inc(beat && state == WIN_RUN), .count(acc)
    );

    always_comb begin
        state_next = window_dset ? ((window_din != '0) ? WIN_RUN : WIN_DISABLED) : state;
        win_end    = !window_dset && state == WIN_RUN && timer == window_dout - 1'b1;
        win_clr    = window_dset || state == WIN_DISABLED || win_end;
        rate_next  = beat ? COUNTER_WIDTH'(sat_inc(sat_t'(acc), COUNTER_WIDTH)) : acc;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state       <= WIN_DISABLED;
            window_dout <= '0;
            timer       <= '0;
            rate_dout   <= '0;
            sample_dout <= '0;
        end else begin
            state       <= state_next;
            window_dout <= window_dset ? window_din : window_dout;
            timer       <= win_clr ? '0 : timer + 1'b1;
            rate_dout   <= win_end ? rate_next : rate_dout;
            sample_dout <= sample_dset ? sample_din : beat ? s_tdata : sample_dout;
        end

`ifdef AXIS_MONITOR_PEAK_EN
    logic peak_seen;
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            peak_dout <= '0;
            peak_seen <= 1'b0;
        end else if (peak_dset) begin
            peak_dout <= '0;
            peak_seen <= 1'b0;
        end else if (beat && (!peak_seen || $signed(s_tdata) > $signed(peak_dout))) begin
            peak_dout <= s_tdata;
            peak_seen <= 1'b1;
        end
`else
    logic unused_peak_dset;
    assign unused_peak_dset = peak_dset;
    assign peak_dout = '0;
`endif
endmodule

// File: tb/tb_axis_window_monitor.sv
// tb_axis_window_monitor: directed and randomized checks against a cycle-level behavioural model
module tb_axis_window_monitor;
    localparam int DW = 16, CW = 4, WW = 8, MAXC = 15;
`ifdef AXIS_MONITOR_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic clock = 1'b0, reset = 1'b1;
    logic [DW-1:0] s_tdata = '0, m_tdata, sample_dout, sample_din = '0, peak_dout;
    logic s_tvalid = 1'b0, s_tready, m_tvalid, m_tready = 1'b0;
    logic [CW-1:0] beats_dout, stalls_dout, rate_dout;
    logic [WW-1:0] window_dout, window_din = '0;
    logic beats_dset = 0, stalls_dset = 0, sample_dset = 0, window_dset = 0, peak_dset = 0;

    int total = 0, bad = 0;
    int mb, ms, mrate, mwb, mel, mlen;
    logic [DW-1:0] msample, mpeak;
    bit mhas;

    axis_window_monitor #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
        .clock(clock), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .beats_dout(beats_dout), .beats_dset(beats_dset),
        .stalls_dout(stalls_dout), .stalls_dset(stalls_dset),
        .sample_dout(sample_dout), .sample_din(sample_din), .sample_dset(sample_dset),
        .window_dout(window_dout), .window_din(window_din), .window_dset(window_dset),
        .rate_dout(rate_dout), .peak_dout(peak_dout), .peak_dset(peak_dset)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        mb = 0; ms = 0; mrate = 0; mwb = 0; mel = 0; mlen = 0;
        msample = '0; mpeak = '0; mhas = 0;
    endtask

    // Advance one clock, apply the specification's rules to the inputs that were present, clear pulses.
    task automatic cyc();
        bit b;
        @(posedge clock);
        b = s_tvalid && m_tready;
        if (reset) model_reset();
        else begin
            mb = beats_dset ? 0 : (b && mb < MAXC) ? mb + 1 : mb;
            ms = stalls_dset ? 0 : (s_tvalid && !m_tready && ms < MAXC) ? ms + 1 : ms;
            if (sample_dset) msample = sample_din;
            else if (b) msample = s_tdata;
            if (PEAK_EN) begin
                if (peak_dset) begin mpeak = '0; mhas = 0; end
                else if (b && (!mhas || $signed(s_tdata) > $signed(mpeak))) begin mpeak = s_tdata; mhas = 1; end
            end
            if (window_dset) begin mlen = int'(window_din); mel = 0; mwb = 0; end
            else if (mlen != 0) begin
                mel++;
                if (b) mwb++;
                if (mel == mlen) begin mrate = (mwb > MAXC) ? MAXC : mwb; mel = 0; mwb = 0; end
            end
        end
        #1;
        beats_dset = 0; stalls_dset = 0; sample_dset = 0; window_dset = 0; peak_dset = 0;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        reset = 1'b0;
        total += 6;
        if (beats_dout !== '0) begin bad++; $display("FAIL reset_beats got %0h want 0", beats_dout); end
        if (stalls_dout !== '0) begin bad++; $display("FAIL reset_stalls got %0h want 0", stalls_dout); end
        if (sample_dout !== '0) begin bad++; $display("FAIL reset_sample got %0h want 0", sample_dout); end
        if (window_dout !== '0) begin bad++; $display("FAIL reset_window got %0h want 0", window_dout); end
        if (rate_dout !== '0) begin bad++; $display("FAIL reset_rate got %0h want 0", rate_dout); end
        if (peak_dout !== '0) begin bad++; $display("FAIL reset_peak got %0h want 0", peak_dout); end
    endtask

    task automatic test_passthrough_counts();
        logic [DW-1:0] d, last;
        last = '0;
        for (int i = 0; i < 8; i++) begin
            d = DW'($urandom);
            s_tdata = d; s_tvalid = 1'b1; m_tready = (i < 5);
            if (i < 5) last = d;
            #1;
            total++;
            if (m_tdata !== d || m_tvalid !== 1'b1 || s_tready !== (i < 5)) begin
                bad++; $display("FAIL mirror got %0h/%0b/%0b want %0h/1/%0b", m_tdata, m_tvalid, s_tready, d, i < 5);
            end
            cyc();
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        total += 3;
        if (beats_dout !== 4'd5) begin bad++; $display("FAIL beats5 got %0d want 5", beats_dout); end
        if (stalls_dout !== 4'd3) begin bad++; $display("FAIL stalls3 got %0d want 3", stalls_dout); end
        if (sample_dout !== last) begin bad++; $display("FAIL last_sample got %0h want %0h", sample_dout, last); end
    endtask

    task automatic test_dset_priority();
        s_tvalid = 1'b1; m_tready = 1'b1;
        s_tdata = 16'h0011; cyc();
        s_tdata = 16'h0022; cyc();
        total++;
        if (beats_dout !== 4'd7) begin bad++; $display("FAIL beats7 got %0d want 7", beats_dout); end
        beats_dset = 1'b1; cyc();
        total++;
        if (beats_dout !== 4'd0) begin bad++; $display("FAIL beats_dset_prio got %0d want 0", beats_dout); end
        s_tdata = 16'hBEEF; sample_din = 16'h1234; sample_dset = 1'b1; cyc();
        total += 2;
        if (sample_dout !== 16'h1234) begin bad++; $display("FAIL sample_dset_prio got %0h want 1234", sample_dout); end
        if (beats_dout !== 4'd1) begin bad++; $display("FAIL beats_after_clear got %0d want 1", beats_dout); end
        s_tvalid = 1'b0;
    endtask

    task automatic test_window();
        window_din = 8'd10; window_dset = 1'b1; cyc();
        for (int k = 1; k <= 50; k++) begin
            s_tvalid = k[0]; m_tready = 1'b1; s_tdata = DW'($urandom);
            cyc();
            if (k == 9) begin
                total++;
                if (rate_dout !== 4'd0) begin bad++; $display("FAIL rate_early got %0d want 0", rate_dout); end
            end
            if (k >= 10) begin
                total++;
                if (rate_dout !== 4'd5) begin bad++; $display("FAIL rate50 k=%0d got %0d want 5", k, rate_dout); end
            end
        end
        window_din = 8'd0; window_dset = 1'b1; cyc();
        total++;
        if (window_dout !== 8'd0) begin bad++; $display("FAIL window_off got %0d want 0", window_dout); end
        for (int k = 0; k < 25; k++) begin
            s_tvalid = 1'($urandom); m_tready = 1'($urandom);
            cyc();
            total++;
            if (rate_dout !== 4'd5) begin bad++; $display("FAIL rate_hold got %0d want 5", rate_dout); end
        end
    endtask

    task automatic test_saturation();
        s_tvalid = 1'b0; beats_dset = 1'b1; cyc();
        s_tvalid = 1'b1; m_tready = 1'b1;
        for (int k = 0; k < 20; k++) cyc();
        total++;
        if (beats_dout !== 4'd15) begin bad++; $display("FAIL beats_sat got %0d want 15", beats_dout); end
        window_din = 8'd20; window_dset = 1'b1; cyc();
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 19) begin
                total++;
                if (rate_dout !== 4'd5) begin bad++; $display("FAIL rate_before_sat got %0d want 5", rate_dout); end
            end
        end
        total++;
        if (rate_dout !== 4'd15) begin bad++; $display("FAIL rate_sat got %0d want 15", rate_dout); end
    endtask

    task automatic test_reset_mid_window();
        window_din = 8'd6; window_dset = 1'b1; cyc();
        for (int k = 0; k < 3; k++) begin s_tvalid = 1'($urandom); s_tdata = DW'($urandom); cyc(); end
        reset = 1'b1;
        #1;
        model_reset();
        total += 6;
        if (beats_dout !== '0) begin bad++; $display("FAIL areset_beats got %0h want 0", beats_dout); end
        if (stalls_dout !== '0) begin bad++; $display("FAIL areset_stalls got %0h want 0", stalls_dout); end
        if (sample_dout !== '0) begin bad++; $display("FAIL areset_sample got %0h want 0", sample_dout); end
        if (window_dout !== '0) begin bad++; $display("FAIL areset_window got %0h want 0", window_dout); end
        if (rate_dout !== '0) begin bad++; $display("FAIL areset_rate got %0h want 0", rate_dout); end
        if (peak_dout !== '0) begin bad++; $display("FAIL areset_peak got %0h want 0", peak_dout); end
        #2 reset = 1'b0;
        s_tvalid = 1'b1; m_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            total++;
            if (rate_dout !== 4'd0) begin bad++; $display("FAIL rate_after_reset got %0d want 0", rate_dout); end
        end
        window_din = 8'd6; window_dset = 1'b1; cyc();
        for (int k = 1; k <= 6; k++) begin
            cyc();
            total++;
            if (rate_dout !== ((k == 6) ? 4'd6 : 4'd0)) begin
                bad++; $display("FAIL rate_new_window k=%0d got %0d want %0d", k, rate_dout, (k == 6) ? 6 : 0);
            end
        end
    endtask

    task automatic test_peak();
        logic [DW-1:0] vals [4];
        logic [DW-1:0] exp;
        vals[0] = -16'sd3; vals[1] = 16'sd7; vals[2] = -16'sd100; vals[3] = 16'sd2;
        s_tvalid = 1'b0; peak_dset = 1'b1; cyc();
        s_tvalid = 1'b1; m_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin s_tdata = vals[k]; cyc(); end
        exp = PEAK_EN ? 16'd7 : 16'd0;
        total++;
        if (peak_dout !== exp) begin bad++; $display("FAIL peak_max got %0h want %0h", peak_dout, exp); end
        s_tvalid = 1'b0; peak_dset = 1'b1; cyc();
        s_tvalid = 1'b1; s_tdata = -16'sd5; cyc();
        exp = PEAK_EN ? 16'hFFFB : 16'd0;
        total++;
        if (peak_dout !== exp) begin bad++; $display("FAIL peak_after_clear got %0h want %0h", peak_dout, exp); end
        s_tvalid = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            s_tdata = DW'($urandom); s_tvalid = ($urandom_range(3) != 0); m_tready = ($urandom_range(3) != 0);
            beats_dset = ($urandom_range(29) == 0); stalls_dset = ($urandom_range(29) == 0);
            sample_din = DW'($urandom); sample_dset = ($urandom_range(9) == 0);
            peak_dset = ($urandom_range(19) == 0);
            window_din = WW'($urandom_range(12)); window_dset = ($urandom_range(24) == 0);
            #1;
            total++;
            if (m_tdata !== s_tdata || m_tvalid !== s_tvalid || s_tready !== m_tready) begin
                bad++; $display("FAIL rnd_mirror k=%0d got %0h/%0b/%0b", k, m_tdata, m_tvalid, s_tready);
            end
            cyc();
            total += 6;
            if (beats_dout !== CW'(mb)) begin bad++; $display("FAIL rnd_beats k=%0d got %0d want %0d", k, beats_dout, mb); end
            if (stalls_dout !== CW'(ms)) begin bad++; $display("FAIL rnd_stalls k=%0d got %0d want %0d", k, stalls_dout, ms); end
            if (sample_dout !== msample) begin bad++; $display("FAIL rnd_sample k=%0d got %0h want %0h", k, sample_dout, msample); end
            if (window_dout !== WW'(mlen)) begin bad++; $display("FAIL rnd_window k=%0d got %0d want %0d", k, window_dout, mlen); end
            if (rate_dout !== CW'(mrate)) begin bad++; $display("FAIL rnd_rate k=%0d got %0d want %0d", k, rate_dout, mrate); end
            if (peak_dout !== mpeak) begin bad++; $display("FAIL rnd_peak k=%0d got %0h want %0h", k, peak_dout, mpeak); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_passthrough_counts();
        test_dset_priority();
        test_window();
        test_saturation();
        test_reset_mid_window();
        test_peak();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
